// File: rtl/cpu_multicycle_sequencer.sv
// rtl/cpu_multicycle_sequencer.sv - LEGv8 multi-cycle control sequencer
module cpu_multicycle_sequencer #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [10:0]        inst31_21,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg2loc,
  output logic               mem_to_reg,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_src,
  output logic               reg_write,
  output logic               halted,
  output logic [1:0]         fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last wait count before the access is declared dead.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Instruction class; ADD/ADDI/SUB/AND/ORR share one class as they only
  // differ in the datapath mux settings.
  typedef enum logic [2:0] {
    K_NONE, K_LDUR, K_STUR, K_ALU, K_B, K_CBZ, K_CBNZ, K_HALT
  } kind_t;

  state_t            cur, nxt;
  kind_t             kind, dec_kind;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire, timeout, halt_entry;
  logic              dec_reg2loc, dec_mem_to_reg;
  logic [1:0]        dec_alu_op, dec_alu_src;

  // Opcode decode of the IR field, with the table's don't-care bits.
  always_comb begin
    dec_kind       = K_NONE;
    dec_reg2loc    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_op     = 2'b00;
    dec_alu_src    = 2'b00;
    casez (inst31_21)
      11'b11111000010: begin
        dec_kind       = K_LDUR;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 2'b01;
      end
      11'b11111000000: begin
        dec_kind    = K_STUR;
        dec_reg2loc = 1'b1;
        dec_alu_src = 2'b01;
      end
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        dec_kind   = K_ALU;
        dec_alu_op = 2'b10;
      end
      11'b1001000100?: begin
        dec_kind    = K_ALU;
        dec_alu_op  = 2'b10;
        dec_alu_src = 2'b10;
      end
      11'b10110100???: begin
        dec_kind    = K_CBZ;
        dec_reg2loc = 1'b1;
        dec_alu_op  = 2'b01;
      end
      11'b10110101???: begin
        dec_kind    = K_CBNZ;
        dec_reg2loc = 1'b1;
        dec_alu_op  = 2'b01;
      end
      11'b000101?????: dec_kind = K_B;
      11'b11111111111: dec_kind = K_HALT;
      default:         dec_kind = K_NONE;
    endcase
  end

  // Next-state logic and state-decoded strobes; FETCH qualifies on mem_ready.
  always_comb begin
    nxt       = cur;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    timeout   = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          nxt     = S_FAULT;
        end
      end
      S_DECODE: begin
        case (dec_kind)
          K_HALT:  nxt = S_HALT;
          K_NONE:  nxt = S_FAULT;
          default: nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind)
          K_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end
          K_CBZ: begin
            pc_write = 1'b1;
            pc_src   = alu_zero;
            retire   = 1'b1;
          end
          K_CBNZ: begin
            pc_write = 1'b1;
            pc_src   = ~alu_zero;
            retire   = 1'b1;
          end
          K_LDUR, K_STUR: nxt = S_MEM;
          default:        nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (kind == K_STUR);
        if (mem_ready) begin
          if (kind == K_STUR) retire = 1'b1;
          else                nxt    = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          nxt     = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: nxt = cur;
    endcase
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

  assign halt_entry = (cur == S_DECODE) && (dec_kind == K_HALT);
  assign state      = cur;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Wait counter, latched decode results, status flags and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      kind        <= K_NONE;
      reg2loc     <= 1'b0;
      mem_to_reg  <= 1'b0;
      alu_op      <= 2'b00;
      alu_src     <= 2'b00;
      halted      <= 1'b0;
      fault       <= 2'b00;
      instr_count <= '0;
    end else begin
      if (nxt != cur)                 wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (cur == S_DECODE) begin
        kind       <= dec_kind;
        reg2loc    <= dec_reg2loc;
        mem_to_reg <= dec_mem_to_reg;
        alu_op     <= dec_alu_op;
        alu_src    <= dec_alu_src;
      end
      if (halt_entry) halted <= 1'b1;
      if (cur == S_DECODE && dec_kind == K_NONE) fault <= 2'b01;
      if (timeout) fault <= 2'b10;
      if ((retire || halt_entry) && instr_count != '1)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: doc/cpu_multicycle_sequencer.md
Name: cpu_multicycle_sequencer

Overview:
Multi-cycle control FSM for the LEGv8 datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence and drives per-state strobes: PC, IR, memory and register file. It handshakes with a shared instruction/data memory port, counts retired instructions, and stops on HALT, an illegal opcode or a memory timeout.

Parameters:
COUNT_W, 16, width of retired-instruction counter (saturating)
MEM_TIMEOUT, 64, max wait cycles for mem_ready before fault (>=1)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  start/continue request
inst31_21  in  11  opcode field of IR; valid from the cycle after ir_load
alu_zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completion; sampled only while mem_req=1
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  write enable (STUR data phase only)
mem_sel  out  1  0 = instruction address (PC), 1 = ALU result address
ir_load  out  1  IR capture pulse; datapath also saves old_pc
pc_write  out  1  PC update pulse
pc_src  out  1  0 = PC+4, 1 = old_pc + branch offset
reg2loc, mem_to_reg  out  1 each  datapath muxes, held for the instruction
alu_op  out  2  00 add (LDUR/STUR/B), 01 pass-B (CBZ/CBNZ), 10 funct (ADD/ADDI/SUB/AND/ORR)
alu_src  out  2  00 register, 01 D-offset, 10 12-bit immediate
reg_write  out  1  register file write pulse
halted  out  1  HALT retired
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout
state  out  3  FSM state for debug
instr_count  out  COUNT_W  retired instructions

Behaviour:
- Reset, synchronous on any cycle including mid-access: state=IDLE. All strobes, muxes, alu_op, alu_src, halted, fault and instr_count are 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, mem_sel=0. When mem_ready=1 in the same cycle, pulse ir_load=1 and pc_write=1 with pc_src=0, then -> DECODE.
- DECODE: decode with don't-cares:
  - LDUR 11111000010; STUR 11111000000; ADD 10001011000; ADDI 1001000100x; SUB 11001011000; AND 10001010000; ORR 10101010000; CBZ 10110100xxx; CBNZ 10110101xxx; B 000101xxxxx; HALT 11111111111.
  - Register reg2loc (1 for STUR/CBZ/CBNZ), mem_to_reg (1 for LDUR), alu_op and alu_src at this edge; they are held until the next DECODE or reset.
  - HALT -> HALT. No match -> FAULT with fault=01. Otherwise -> EXEC.
- EXEC:
  - B: pc_write=1, pc_src=1.
  - CBZ: pc_write=1, pc_src=alu_zero. CBNZ: pc_write=1, pc_src=~alu_zero.
  - Branches retire here. LDUR/STUR -> MEM. R-type/ADDI -> WB.
- MEM: mem_req=1, mem_sel=1, mem_we=1 for STUR only. On mem_ready: STUR retires, LDUR -> WB.
- WB: reg_write=1 for exactly one cycle, then retire. reg_write is never asserted for STUR, branches or HALT.
- Retire: instr_count+1, saturating at all-ones. Next state is FETCH if run=1, IDLE if run=0. run is ignored in every other state.
- Zero-wait latency (clk cycles): branch 3, R-type/ADDI 4, STUR 4, LDUR 5. Each mem_ready wait cycle adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments on each cycle with mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT, go -> FAULT with fault=10 and drop mem_req.
  - mem_ready on the same edge as the timeout wins: the access completes.
- HALT: halted=1, instr_count+1 on entry. HALT and FAULT are absorbing until reset, with all strobes 0.
- Strobes (mem_req, ir_load, pc_write, reg_write) are Moore/state-decoded. ir_load and pc_write in FETCH qualify combinationally on mem_ready.

Test Plan:
- Reset mid-MEM with mem_req=1 -> next edge: state=0, mem_req=0, instr_count=0, fault=00.
- run=1, ADD 10001011000, mem_ready always 1 -> state 1,2,3,5. reg_write high one cycle in WB, alu_op=10, alu_src=00, instr_count=1. Back to FETCH in the 5th cycle.
- LDUR with data mem_ready delayed 3 cycles -> mem_req held 4 cycles, mem_sel=1, mem_we=0. WB has mem_to_reg=1, reg_write=1. Total 8 cycles.
- CBZ 10110100101 with alu_zero=1, then CBNZ with alu_zero=1 -> first gives pc_write=1, pc_src=1; second gives pc_write=1, pc_src=0. reg_write=0 for both; instr_count +2.
- Opcode 00000000000 -> FAULT, fault=01, no further mem_req. HALT 11111111111 -> halted=1, state=6, instr_count incremented, stays through 20 idle cycles.
- FETCH with mem_ready=0 for MEM_TIMEOUT=4 cycles -> FAULT, fault=10. Separately, mem_ready on the 4th wait cycle -> normal DECODE. run=0 at retire -> IDLE.
